// File: rtl/round_scorer.sv
// round_scorer: keeps per-player match scores for the tug-of-war game,
// shows them on two active-low seven-segment digits, holds the final round
// position for a while and then pulses round_reset to re-arm the playfield.
// The match stops (no more restarts) once a player reaches WIN_SCORE.
module round_scorer #(
    parameter int unsigned WIN_SCORE   = 7,        // 1..9
    parameter int unsigned HOLD_CYCLES = 25000000  // >= 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       round_over,
    input  logic       winner_left,
    input  logic       new_match,
    output logic       round_reset,
    output logic       match_over,
    output logic       match_winner_left,
    output logic [6:0] hex_left,
    output logic [6:0] hex_right
);

    // Hold counter only has to reach HOLD_CYCLES-1.
    localparam int unsigned    CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [3:0]     WIN       = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        HOLD       = 2'd1,
        RESTART    = 2'd2,
        MATCH_OVER = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    score_l_q, score_l_d;
    logic [3:0]    score_r_q, score_r_d;
    logic          round_over_q;
    logic          match_over_q, match_over_d;
    logic          mwl_q, mwl_d;

    logic          round_rise;
    logic [3:0]    score_l_inc;
    logic [3:0]    score_r_inc;

    // Active-low gfedcba pattern for one decimal digit; blank for non-digits.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign round_rise  = round_over & ~round_over_q;
    assign score_l_inc = score_l_q + 4'd1;
    assign score_r_inc = score_r_q + 4'd1;

    // Delayed copy of round_over for rising-edge detection, every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            round_over_q <= 1'b0;
        end else begin
            round_over_q <= round_over;
        end
    end

    // State, hold counter, scores and match result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PLAY;
            cnt_q        <= '0;
            score_l_q    <= 4'd0;
            score_r_q    <= 4'd0;
            match_over_q <= 1'b0;
            mwl_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            match_over_q <= match_over_d;
            mwl_q        <= mwl_d;
        end
    end

    // Next-state logic; new_match overrides everything, including a point
    // that would otherwise be credited on the same cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        score_l_d    = score_l_q;
        score_r_d    = score_r_q;
        match_over_d = match_over_q;
        mwl_d        = mwl_q;

        if (new_match) begin
            state_d      = RESTART;
            cnt_d        = '0;
            score_l_d    = 4'd0;
            score_r_d    = 4'd0;
            match_over_d = 1'b0;
            mwl_d        = 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (round_rise) begin
                        if (winner_left) begin
                            score_l_d = score_l_inc;
                            if (score_l_inc == WIN) begin
                                state_d      = MATCH_OVER;
                                match_over_d = 1'b1;
                                mwl_d        = 1'b1;
                            end else begin
                                state_d = HOLD;
                                cnt_d   = '0;
                            end
                        end else begin
                            score_r_d = score_r_inc;
                            if (score_r_inc == WIN) begin
                                state_d      = MATCH_OVER;
                                match_over_d = 1'b1;
                                mwl_d        = 1'b0;
                            end else begin
                                state_d = HOLD;
                                cnt_d   = '0;
                            end
                        end
                    end
                end
                HOLD: begin
                    // Final position stays frozen for HOLD_CYCLES cycles.
                    if (cnt_q == HOLD_LAST) begin
                        state_d = RESTART;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RESTART: begin
                    // Keep the playfield in reset until it drops game_over.
                    if (!round_over) begin
                        state_d = PLAY;
                    end
                end
                MATCH_OVER: begin
                    state_d = MATCH_OVER;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end
    end

    assign round_reset       = (state_q == RESTART);
    assign match_over        = match_over_q;
    assign match_winner_left = mwl_q;
    assign hex_left          = seg7(score_l_q);
    assign hex_right         = seg7(score_r_q);

endmodule

// File: doc/round_scorer.md
Name: round_scorer

Overview:
- Downstream of the tug-of-war round logic (light chain plus victory detector).
- Consumes the round-over level and the winner indication, and keeps per-player match scores.
- Drives two seven-segment score digits.
- After a short hold, issues a round-restart pulse that re-arms the playfield. The playfield's synchronous reset is driven by round_reset.
- The match ends when either player reaches WIN_SCORE.

Parameters:
- WIN_SCORE, 7, score that ends the match; legal range 1..9.
- HOLD_CYCLES, 25000000, cycles the final round position stays frozen before restart (0.5 s at 50 MHz); must be >= 1.

Ports:
- clk  input  1  system clock (CLOCK_50).
- reset_n  input  1  asynchronous, active-low reset.
- round_over  input  1  level; high while the playfield reports the round finished (game_over).
- winner_left  input  1  valid when round_over is high; 1 = left player won, 0 = right player won.
- new_match  input  1  synchronised single-cycle pulse; clears scores and restarts play.
- round_reset  output  1  active-high reset request to the playfield.
- match_over  output  1  high once a player reaches WIN_SCORE.
- match_winner_left  output  1  valid while match_over is high; 1 = left player won the match.
- hex_left  output  7  active-low seven-segment digit for the left score (drives HEX5).
- hex_right  output  7  active-low seven-segment digit for the right score (drives HEX0).

Behaviour:
- Asynchronous reset (reset_n=0) sets:
  - score_l = score_r = 0, state = PLAY, hold counter = 0, round_over_q = 0.
  - round_reset = 0, match_over = 0, match_winner_left = 0.
  - hex_left = hex_right = 7'b1000000 (digit 0).
- Scores are 4-bit unsigned and never exceed WIN_SCORE. No wrap; no increment occurs outside PLAY.
- Hex encoding, segments gfedcba, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Outputs are registered or decoded from registered scores; latency from the scoring edge to the updated digit is 1 cycle.
- Rise detection: round_rise = round_over & ~round_over_q. round_over_q is registered every cycle.
- States: PLAY, HOLD, RESTART, MATCH_OVER.
- PLAY:
  - On round_rise, winner_left is sampled in the same cycle and the winner's score increments.
  - If the incremented score equals WIN_SCORE, next state is MATCH_OVER. match_over and match_winner_left are registered on that same edge.
  - Otherwise next state is HOLD and the counter clears to 0.
  - A round_over level that stays high without a rising edge is ignored.
- HOLD:
  - Counter increments each cycle.
  - When the counter reaches HOLD_CYCLES-1, next state is RESTART.
  - round_reset stays 0 throughout HOLD.
- RESTART:
  - round_reset = 1, a Moore output of the state.
  - Stays in RESTART until round_over is sampled 0; the next cycle enters PLAY with round_reset = 0.
  - Minimum round_reset width is 1 cycle.
- MATCH_OVER:
  - Terminal state; scores, match_over and match_winner_left hold.
  - round_reset = 0, so the final board stays visible.
  - round_over edges are ignored.
- new_match, in any state, has top priority:
  - Scores clear to 0, match_over and match_winner_left clear, counter clears, next state is RESTART.
  - If new_match coincides with round_rise in PLAY, no point is credited.
- reset_n asserted mid-HOLD or mid-RESTART returns immediately to the reset values; no restart pulse is emitted.
- winner_left is don't-care when round_over is low.

Test Plan (WIN_SCORE=3, HOLD_CYCLES=4):
- Reset release with round_over=0 -> hex_left = hex_right = 1000000, round_reset = 0, match_over = 0.
- round_over rises with winner_left=1 -> next cycle hex_left = 1111001 (digit 1). round_reset is 0 for 4 cycles, then 1 until round_over is driven 0, then 0 on the following cycle.
- Right player wins 3 rounds (each with round_over deasserted after round_reset) -> hex_right = 0110000 (digit 3), match_over = 1, match_winner_left = 0, and round_reset never asserts after the third point.
- In MATCH_OVER, toggle round_over 0->1->0 -> scores unchanged. Then a new_match pulse -> both digits read 0, match_over = 0, round_reset = 1 for exactly 1 cycle (round_over already 0), then PLAY.
- new_match in the same cycle as a round_over rise -> no increment, both scores 0, RESTART entered.
- reset_n pulsed low during HOLD (counter = 2) -> outputs return to reset values asynchronously; round_reset never asserts.
